// File: rtl/phy_reg_file_mp.sv
// -----------------------------------------------------------------------------
// phy_reg_file_mp
//
// Multi-ported physical register file for an out-of-order core. Each physical
// tag holds a DATA_W value plus a ready bit. Writes come from the complete
// stage (CDB), ready-bit clears come from the rename stage, and every read port
// returns registered data and ready bit one cycle after sampling its tag.
// Tag 0 is hardwired: it always reads as 0 and is always ready.
//
// Configuration macro:
//   PRF_BYPASS_EN  - when defined, a read sampled on the same edge as a write
//                    to the same tag returns the new write data with ready=1
//                    (ready=0 if that tag is also allocated on that edge).
//                    When undefined, such a read returns the pre-edge contents
//                    and pre-edge ready bit (read-before-write).
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   rd_addr    in   NUM_RD packed read tags, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    out  NUM_RD packed registered read data
//   rd_rdy     out  NUM_RD registered ready bits
//   wr_en      in   NUM_WR per-port write enables
//   wr_addr    in   NUM_WR packed write tags
//   wr_data    in   NUM_WR packed write values
//   alloc_en   in   rename allocates alloc_addr (clears its ready bit)
//   alloc_addr in   tag being allocated
// -----------------------------------------------------------------------------
module phy_reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 64,
  parameter int ADDR_W   = 6,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_rdy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       alloc_en,
  input  logic [ADDR_W-1:0]          alloc_addr
);

  // Storage and per-tag ready bits.
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] ready_q;
  logic [NUM_REGS-1:0] ready_d;

  // Ready-bit next state: writes set, then alloc clears so that an alloc of a
  // tag wins over a write of the same tag on the same edge. Tag 0 stays ready.
  always_comb begin
    ready_d = ready_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
        ready_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    if (alloc_en && (alloc_addr != '0)) begin
      ready_d[alloc_addr] = 1'b0;
    end
    ready_d[0] = 1'b1;
  end

  // Data storage. Later loop iterations override earlier ones, so the highest
  // write port wins when several ports hit the same tag on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      ready_q <= '1;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
          regs_q[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
      ready_q <= ready_d;
    end
  end

  // Independent read ports, each with its own output register.
  logic [DATA_W-1:0] rd_data_q [NUM_RD];
  logic              rd_rdy_q  [NUM_RD];

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data_d;
    logic              rdy_d;

    assign tag = rd_addr[gi*ADDR_W +: ADDR_W];

    always_comb begin
      data_d = regs_q[tag];
      rdy_d  = ready_q[tag];
`ifdef PRF_BYPASS_EN
      // Forward same-edge write data; highest matching port wins. A same-edge
      // alloc of that tag means the value belongs to a stale producer, so the
      // reader must see it as not ready.
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == tag)) begin
          data_d = wr_data[j*DATA_W +: DATA_W];
          rdy_d  = !(alloc_en && (alloc_addr == tag));
        end
      end
`endif
      if (tag == '0) begin
        data_d = '0;
        rdy_d  = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q[gi] <= '0;
        rd_rdy_q[gi]  <= 1'b1;
      end else begin
        rd_data_q[gi] <= data_d;
        rd_rdy_q[gi]  <= rdy_d;
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = rd_data_q[gi];
    assign rd_rdy[gi]                   = rd_rdy_q[gi];
  end

endmodule

// File: tb/tb_phy_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tb_phy_reg_file_mp
//
// Directed plus pseudo-random traffic for phy_reg_file_mp. A behavioural model
// (plain arrays of values and ready flags) predicts every read port each cycle;
// a negedge process compares the DUT against it, and literal expectations pin
// the key scenarios. Honours PRF_BYPASS_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_phy_reg_file_mp;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 64;
  localparam int ADDR_W   = 6;
  localparam int NUM_RD   = 4;
  localparam int NUM_WR   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_rdy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;

  phy_reg_file_mp #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_rdy(rd_rdy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [DATA_W-1:0] m_mem [NUM_REGS];
  bit                m_rdy [NUM_REGS];
  logic [DATA_W-1:0] pend_data [NUM_RD];
  bit                pend_rdy  [NUM_RD];
  logic [DATA_W-1:0] exp_data  [NUM_RD];
  bit                exp_rdy   [NUM_RD];
  bit                exp_valid = 1'b0;

  // Predict what each read port shows after the coming edge, then apply the
  // edge's effect on the register file contents.
  task automatic model_step();
    int t, wt;
    for (int i = 0; i < NUM_RD; i++) begin
      t = int'(rd_addr[i*ADDR_W +: ADDR_W]);
      if (rst) begin
        pend_data[i] = '0; pend_rdy[i] = 1'b1;
      end else if (t == 0) begin
        pend_data[i] = '0; pend_rdy[i] = 1'b1;
      end else begin
        pend_data[i] = m_mem[t]; pend_rdy[i] = m_rdy[t];
`ifdef PRF_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && int'(wr_addr[j*ADDR_W +: ADDR_W]) == t) begin
            pend_data[i] = wr_data[j*DATA_W +: DATA_W];
            pend_rdy[i]  = !(alloc_en && int'(alloc_addr) == t);
          end
        end
`endif
      end
    end
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        m_mem[r] = '0; m_rdy[r] = 1'b1;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        wt = int'(wr_addr[j*ADDR_W +: ADDR_W]);
        if (wr_en[j] && wt != 0) begin
          m_mem[wt] = wr_data[j*DATA_W +: DATA_W];
          m_rdy[wt] = 1'b1;
        end
      end
      if (alloc_en && alloc_addr != '0) m_rdy[int'(alloc_addr)] = 1'b0;
    end
  endtask

  // One clock: predict, take the edge, publish expectations, then return
  // shortly after the following negedge (after the compare process ran).
  task automatic cycle();
    model_step();
    @(posedge clk);
    for (int i = 0; i < NUM_RD; i++) begin
      exp_data[i] = pend_data[i];
      exp_rdy[i]  = pend_rdy[i];
    end
    exp_valid = 1'b1;
    @(negedge clk);
    #1;
  endtask

  // Model comparison on every cycle once expectations exist.
  always @(negedge clk) begin
    if (exp_valid) begin
      for (int i = 0; i < NUM_RD; i++) begin
        checks++;
        if (rd_data[i*DATA_W +: DATA_W] !== exp_data[i] || rd_rdy[i] !== exp_rdy[i]) begin
          errors++;
          $display("FAIL model port%0d: got data=%h rdy=%b, expected data=%h rdy=%b",
                   i, rd_data[i*DATA_W +: DATA_W], rd_rdy[i], exp_data[i], exp_rdy[i]);
        end
      end
    end
  end

  task automatic lit(input string name, input int p, input logic [DATA_W-1:0] d, input logic r);
    checks++;
    if (rd_data[p*DATA_W +: DATA_W] !== d || rd_rdy[p] !== r) begin
      errors++;
      $display("FAIL %s port%0d: got data=%h rdy=%b, expected data=%h rdy=%b",
               name, p, rd_data[p*DATA_W +: DATA_W], rd_rdy[p], d, r);
    end else begin
      $display("ok   %s port%0d data=%h rdy=%b", name, p, d, r);
    end
  endtask

  task automatic idle_in();
    wr_en = '0; wr_addr = '0; wr_data = '0; alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic rd_all(input logic [ADDR_W-1:0] t);
    for (int i = 0; i < NUM_RD; i++) rd_addr[i*ADDR_W +: ADDR_W] = t;
  endtask

  task automatic set_rd(input int p, input logic [ADDR_W-1:0] t);
    rd_addr[p*ADDR_W +: ADDR_W] = t;
  endtask

  task automatic set_wr(input int p, input logic [ADDR_W-1:0] t, input logic [DATA_W-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*ADDR_W +: ADDR_W] = t;
    wr_data[p*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    for (int r = 0; r < NUM_REGS; r++) begin
      m_mem[r] = '0; m_rdy[r] = 1'b1;
    end
    rst = 1'b1; rd_addr = '0; idle_in();
    @(negedge clk); #1;

    // Reset state.
    cycle(); cycle();
    lit("reset", 0, '0, 1'b1);
    rst = 1'b0;

    // Fresh tags read as zero and ready.
    for (int i = 0; i < NUM_RD; i++) set_rd(i, ADDR_W'(i + 1));
    cycle();
    for (int i = 0; i < NUM_RD; i++) lit("fresh_tags", i, '0, 1'b1);

    // Single write then read on all ports.
    set_wr(0, 6'd5, 32'hDEADBEEF); cycle();
    idle_in(); rd_all(6'd5); cycle();
    for (int i = 0; i < NUM_RD; i++) lit("write_read", i, 32'hDEADBEEF, 1'b1);

    // Same-edge writes to one tag: port 1 wins.
    set_wr(0, 6'd9, 32'h11); set_wr(1, 6'd9, 32'h22); cycle();
    idle_in(); rd_all(6'd9); cycle();
    lit("wr_priority", 2, 32'h22, 1'b1);

    // Write/read collision.
    set_wr(0, 6'd7, 32'hA); cycle();
    idle_in(); set_wr(0, 6'd7, 32'hB); rd_all(6'd7); cycle();
`ifdef PRF_BYPASS_EN
    lit("collision", 0, 32'hB, 1'b1);
`else
    lit("collision", 0, 32'hA, 1'b1);
`endif
    idle_in(); cycle();
    lit("after_collision", 1, 32'hB, 1'b1);

    // Allocation clears ready; write sets it; alloc beats same-edge write.
    alloc_en = 1'b1; alloc_addr = 6'd12; cycle();
    idle_in(); rd_all(6'd12); cycle();
    lit("alloc_clear", 0, '0, 1'b0);
    set_wr(1, 6'd12, 32'h5A); cycle();
    idle_in(); cycle();
    lit("alloc_then_write", 3, 32'h5A, 1'b1);
    set_wr(0, 6'd12, 32'h77); alloc_en = 1'b1; alloc_addr = 6'd12; cycle();
`ifdef PRF_BYPASS_EN
    lit("alloc_write_same_read", 0, 32'h77, 1'b0);
`else
    lit("alloc_write_same_read", 0, 32'h5A, 1'b1);
`endif
    idle_in(); cycle();
    lit("alloc_write_same", 1, 32'h77, 1'b0);

    // Tag 0 is immutable.
    set_wr(1, 6'd0, 32'hFFFF); alloc_en = 1'b1; alloc_addr = 6'd0; rd_all(6'd0); cycle();
    idle_in(); cycle();
    for (int i = 0; i < NUM_RD; i++) lit("tag0", i, '0, 1'b1);

    // Reset in the middle of traffic: writes/alloc on that edge are ignored.
    set_rd(0, 6'd5); set_rd(1, 6'd9); set_rd(2, 6'd7); set_rd(3, 6'd12);
    set_wr(0, 6'd20, 32'h1234); alloc_en = 1'b1; alloc_addr = 6'd21; rst = 1'b1;
    cycle();
    for (int i = 0; i < NUM_RD; i++) lit("mid_reset", i, '0, 1'b1);
    rst = 1'b0; idle_in();
    set_rd(0, 6'd5); set_rd(1, 6'd9); set_rd(2, 6'd20); set_rd(3, 6'd21);
    cycle();
    lit("post_reset_t20", 2, '0, 1'b1);
    lit("post_reset_t21", 3, '0, 1'b1);

    // Dense mixed traffic over a small tag range to force collisions.
    for (int k = 0; k < 80; k++) begin
      idle_in();
      for (int i = 0; i < NUM_RD; i++) set_rd(i, ADDR_W'($urandom_range(0, 15)));
      for (int j = 0; j < NUM_WR; j++) begin
        if ($urandom_range(0, 1) == 1) set_wr(j, ADDR_W'($urandom_range(0, 15)), $urandom);
      end
      alloc_en   = ($urandom_range(0, 3) == 0);
      alloc_addr = ADDR_W'($urandom_range(0, 15));
      rst        = (k == 50);
      cycle();
    end
    rst = 1'b0; idle_in();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
